// File: rtl/tx_rf_frontend_sequencer_pkg.sv
// Shared definitions for the TX RF front-end sequencer: state codes,
// output bundle, and the guard-time scaling helper.
package tx_rf_frontend_sequencer_pkg;

    localparam int FE_STATE_W = 3;
    localparam int DWELL_W    = 17;

    // Codes are visible on fe_state for debug; 5..7 are unused.
    typedef enum logic [FE_STATE_W-1:0] {
        FE_ST_IDLE  = 3'd0,
        FE_ST_LEAD  = 3'd1,
        FE_ST_TX    = 3'd2,
        FE_ST_LAG   = 3'd3,
        FE_ST_BLANK = 3'd4
    } fe_state_e;

    typedef struct packed {
        logic tr_switch_tx;
        logic pa_en;
        logic lna_en;
        logic rx_blank;
        logic fe_busy;
    } fe_out_t;

    // Front-end pin levels for each state. Unused codes look like IDLE.
    function automatic fe_out_t fe_decode(input fe_state_e st);
        fe_out_t o;
        o.tr_switch_tx = 1'b0;
        o.pa_en        = 1'b0;
        o.lna_en       = 1'b1;
        o.rx_blank     = 1'b0;
        o.fe_busy      = 1'b0;
        case (st)
            FE_ST_LEAD, FE_ST_LAG: begin
                o.tr_switch_tx = 1'b1;
                o.lna_en       = 1'b0;
                o.rx_blank     = 1'b1;
                o.fe_busy      = 1'b1;
            end
            FE_ST_TX: begin
                o.tr_switch_tx = 1'b1;
                o.pa_en        = 1'b1;
                o.lna_en       = 1'b0;
                o.rx_blank     = 1'b1;
                o.fe_busy      = 1'b1;
            end
            FE_ST_BLANK: begin
                o.rx_blank     = 1'b1;
                o.fe_busy      = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

    // Guard length in clk cycles; 255 * scale must fit the 17-bit dwell compare.
    function automatic logic [DWELL_W-1:0] fe_scale_top(input logic [7:0] top,
                                                        input int unsigned scale);
        return DWELL_W'(32'(top) * scale);
    endfunction

endpackage

// File: rtl/tx_rf_frontend_sequencer_dwell_timer.sv
// Shared dwell counter for the LEAD/LAG/BLANK guard states. Counts up from 0
// after clr and flags done when the count equals top.
module fe_dwell_timer
    import tx_rf_frontend_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [DWELL_W-1:0] top,
    output logic               done
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    // Clear on state entry, otherwise count up and hold at full scale.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == top);

endmodule

// File: rtl/tx_rf_frontend_sequencer.sv
// TX RF front-end sequencer: drives the T/R switch, PA and LNA around a TX
// burst with guard times, blanks RX after switch-back, and enforces a
// microsecond-tick watchdog on the LEAD+TX duration.
//
// state | meaning
// IDLE  | RX path active, waiting for tx_rf_is_ongoing
// LEAD  | switch on TX path, PA still off (switch settle guard)
// TX    | PA on, RF emitting
// LAG   | PA off, switch still on TX path (PA ramp-down guard)
// BLANK | switch back on RX path, RX detection/AGC still suppressed
module tx_rf_frontend_sequencer
    import tx_rf_frontend_sequencer_pkg::*;
#(
    parameter int COUNT_SCALE = 10,
    parameter int WD_W        = 16
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_rf_is_ongoing,
    input  logic                  tsf_pulse_1M,
    input  logic [7:0]            pa_lead_count_top,
    input  logic [7:0]            pa_lag_count_top,
    input  logic [7:0]            rx_blank_count_top,
    input  logic [WD_W-1:0]       tx_wd_us_top,
    input  logic                  fault_clr,
    output logic                  tr_switch_tx,
    output logic                  pa_en,
    output logic                  lna_en,
    output logic                  rx_blank,
    output logic                  fe_busy,
    output logic                  tx_wd_timeout,
    output logic                  tx_fault_sticky,
    output logic [FE_STATE_W-1:0] fe_state
);

    fe_state_e          state_q;
    fe_state_e          state_d;
    logic [WD_W-1:0]    wd_cnt_q;
    logic [WD_W-1:0]    wd_cnt_d;
    logic               wd_lock_q;
    logic               wd_lock_d;
    logic               wd_expire;
    logic               sticky_q;
    logic               sticky_d;
    logic               timeout_q;
    fe_out_t            out_q;
    fe_out_t            out_d;
    logic [DWELL_W-1:0] dwell_top;
    logic               dwell_clr;
    logic               dwell_done;

    // Pick the guard length for whichever guard state is active.
    always_comb begin
        dwell_top = '0;
        case (state_q)
            FE_ST_LEAD:  dwell_top = fe_scale_top(pa_lead_count_top, COUNT_SCALE);
            FE_ST_LAG:   dwell_top = fe_scale_top(pa_lag_count_top, COUNT_SCALE);
            FE_ST_BLANK: dwell_top = fe_scale_top(rx_blank_count_top, COUNT_SCALE);
            default:     dwell_top = '0;
        endcase
    end

    // Any state change restarts the dwell count at 0 in the new state.
    assign dwell_clr = (state_d != state_q);

    fe_dwell_timer u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (dwell_clr),
        .top  (dwell_top),
        .done (dwell_done)
    );

    // Next state, watchdog count and lock. A new TX request during LAG/BLANK
    // takes priority over that guard's expiry so the switch never toggles
    // needlessly.
    always_comb begin
        state_d   = state_q;
        wd_cnt_d  = wd_cnt_q;
        wd_lock_d = wd_lock_q;
        wd_expire = 1'b0;

        if (state_q == FE_ST_LEAD || state_q == FE_ST_TX) begin
            if (tsf_pulse_1M && (wd_cnt_q != '1)) begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
            wd_expire = (tx_wd_us_top != '0) && (wd_cnt_d == tx_wd_us_top);
        end

        case (state_q)
            FE_ST_IDLE: begin
                if (tx_rf_is_ongoing) begin
                    if (!wd_lock_q) begin
                        state_d  = FE_ST_LEAD;
                        wd_cnt_d = '0;
                    end
                end else begin
                    wd_lock_d = 1'b0;
                end
            end
            FE_ST_LEAD: begin
                if (!tx_rf_is_ongoing || wd_expire) begin
                    state_d = FE_ST_LAG;
                end else if (dwell_done) begin
                    state_d = FE_ST_TX;
                end
            end
            FE_ST_TX: begin
                if (!tx_rf_is_ongoing || wd_expire) begin
                    state_d = FE_ST_LAG;
                end
            end
            FE_ST_LAG: begin
                if (tx_rf_is_ongoing && !wd_lock_q) begin
                    state_d = FE_ST_LEAD;
                end else if (dwell_done) begin
                    state_d = FE_ST_BLANK;
                end
            end
            FE_ST_BLANK: begin
                if (tx_rf_is_ongoing && !wd_lock_q) begin
                    state_d = FE_ST_LEAD;
                end else if (dwell_done) begin
                    state_d = FE_ST_IDLE;
                end
            end
            default: state_d = FE_ST_IDLE;
        endcase

        if (wd_expire) begin
            wd_lock_d = 1'b1;
        end
    end

    // Sticky fault (expiry beats a simultaneous clear) and registered pin levels.
    always_comb begin
        sticky_d = sticky_q;
        if (fault_clr) begin
            sticky_d = 1'b0;
        end
        if (wd_expire) begin
            sticky_d = 1'b1;
        end
        out_d = fe_decode(state_d);
    end

    // State, watchdog and fault registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FE_ST_IDLE;
            wd_cnt_q  <= '0;
            wd_lock_q <= 1'b0;
            sticky_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_cnt_q  <= wd_cnt_d;
            wd_lock_q <= wd_lock_d;
            sticky_q  <= sticky_d;
            timeout_q <= wd_expire;
        end
    end

    // Output pins registered from the next state so they track state_q exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= fe_decode(FE_ST_IDLE);
        end else begin
            out_q <= out_d;
        end
    end

    assign tr_switch_tx    = out_q.tr_switch_tx;
    assign pa_en           = out_q.pa_en;
    assign lna_en          = out_q.lna_en;
    assign rx_blank        = out_q.rx_blank;
    assign fe_busy         = out_q.fe_busy;
    assign tx_wd_timeout   = timeout_q;
    assign tx_fault_sticky = sticky_q;
    assign fe_state        = state_q;

    a_pa_needs_switch: assert property (@(posedge clk) disable iff (rst)
        pa_en |-> tr_switch_tx);

    a_lna_switch_excl: assert property (@(posedge clk) disable iff (rst)
        !(lna_en && tr_switch_tx));

endmodule

// File: tb/tb_tx_rf_frontend_sequencer.sv
module tb_tx_rf_frontend_sequencer;

    localparam int SCALE = 10;

    localparam int PH_IDLE  = 0;
    localparam int PH_LEAD  = 1;
    localparam int PH_TX    = 2;
    localparam int PH_LAG   = 3;
    localparam int PH_BLANK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_on;
    logic        tsf;
    logic [7:0]  lead_top;
    logic [7:0]  lag_top;
    logic [7:0]  blank_top;
    logic [15:0] wd_top;
    logic        fclr;
    logic        tr_switch_tx;
    logic        pa_en;
    logic        lna_en;
    logic        rx_blank;
    logic        fe_busy;
    logic        tx_wd_timeout;
    logic        tx_fault_sticky;
    logic [2:0]  fe_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tx_rf_frontend_sequencer #(.COUNT_SCALE(SCALE), .WD_W(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_rf_is_ongoing   (tx_on),
        .tsf_pulse_1M       (tsf),
        .pa_lead_count_top  (lead_top),
        .pa_lag_count_top   (lag_top),
        .rx_blank_count_top (blank_top),
        .tx_wd_us_top       (wd_top),
        .fault_clr          (fclr),
        .tr_switch_tx       (tr_switch_tx),
        .pa_en              (pa_en),
        .lna_en             (lna_en),
        .rx_blank           (rx_blank),
        .fe_busy            (fe_busy),
        .tx_wd_timeout      (tx_wd_timeout),
        .tx_fault_sticky    (tx_fault_sticky),
        .fe_state           (fe_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (!fe_busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_on = 1'b1; tsf = 1'b1; fclr = 1'b0;
        lead_top = 8'd2; lag_top = 8'd1; blank_top = 8'd3; wd_top = 16'd0;
        tick(); tick(); tick();
        checks++;
        if ({tr_switch_tx, pa_en, lna_en, rx_blank, fe_busy, tx_wd_timeout, tx_fault_sticky, fe_state} !== 10'b00100_00_000) begin
            failures++;
            $display("FAIL reset_hold actual=%b required=%b", {tr_switch_tx, pa_en, lna_en, rx_blank, fe_busy, tx_wd_timeout, tx_fault_sticky, fe_state}, 10'b00100_00_000);
        end
        tx_on = 1'b0; tsf = 1'b0; rst = 1'b0;
        tick();
        checks++;
        if ({tr_switch_tx, pa_en, lna_en, rx_blank, fe_busy, fe_state} !== 8'b00100_000) begin
            failures++;
            $display("FAIL reset_release actual=%b required=%b", {tr_switch_tx, pa_en, lna_en, rx_blank, fe_busy, fe_state}, 8'b00100_000);
        end
    endtask

    task automatic test_nominal();
        int sw_rise = -1, pa_rise = -1, pa_fall = -1, sw_fall = -1, bl_fall = -1, overlap = 0;
        logic p_sw, p_pa, p_bl;
        lead_top = 8'd2; lag_top = 8'd1; blank_top = 8'd3; wd_top = 16'd0;
        p_sw = tr_switch_tx; p_pa = pa_en; p_bl = rx_blank;
        for (int t = 0; t <= 260; t++) begin
            if (tr_switch_tx && !p_sw && sw_rise < 0) sw_rise = t;
            if (pa_en && !p_pa && pa_rise < 0) pa_rise = t;
            if (!pa_en && p_pa && pa_fall < 0) pa_fall = t;
            if (!tr_switch_tx && p_sw && sw_fall < 0) sw_fall = t;
            if (!rx_blank && p_bl && bl_fall < 0) bl_fall = t;
            if (lna_en && tr_switch_tx) overlap++;
            p_sw = tr_switch_tx; p_pa = pa_en; p_bl = rx_blank;
            tx_on = (t < 200);
            tick();
        end
        checks++;
        if (sw_rise !== 1) begin failures++; $display("FAIL nom_sw_rise actual=%0d required=%0d", sw_rise, 1); end
        checks++;
        if (pa_rise !== 1 + 2 * SCALE + 1) begin failures++; $display("FAIL nom_pa_rise actual=%0d required=%0d", pa_rise, 1 + 2 * SCALE + 1); end
        checks++;
        if (pa_fall !== 201) begin failures++; $display("FAIL nom_pa_fall actual=%0d required=%0d", pa_fall, 201); end
        checks++;
        if (sw_fall !== 201 + 1 * SCALE + 1) begin failures++; $display("FAIL nom_sw_fall actual=%0d required=%0d", sw_fall, 201 + SCALE + 1); end
        checks++;
        if (bl_fall !== 212 + 3 * SCALE + 1) begin failures++; $display("FAIL nom_blank_fall actual=%0d required=%0d", bl_fall, 212 + 3 * SCALE + 1); end
        checks++;
        if (overlap !== 0) begin failures++; $display("FAIL nom_lna_overlap actual=%0d required=0", overlap); end
    endtask

    task automatic test_short_tx();
        int code = 0, nseq = 0, pa_seen = 0, lag_at = -1;
        logic [2:0] p_st;
        lead_top = 8'd2; lag_top = 8'd1; blank_top = 8'd3; wd_top = 16'd0;
        p_st = fe_state;
        for (int t = 0; t <= 80; t++) begin
            if (fe_state != p_st) begin
                code = code * 8 + int'(fe_state);
                nseq++;
                if (fe_state == 3'd3 && lag_at < 0) lag_at = t;
            end
            if (pa_en) pa_seen++;
            p_st = fe_state;
            tx_on = (t < 5);
            tick();
        end
        checks++;
        if (pa_seen !== 0) begin failures++; $display("FAIL short_pa_seen actual=%0d required=0", pa_seen); end
        checks++;
        if (nseq !== 4 || code !== ((1 * 8 + 3) * 8 + 4) * 8 + 0) begin
            failures++;
            $display("FAIL short_state_seq actual_code=%0o len=%0d required_code=%0o len=4", code, nseq, 8'o134 * 8);
        end
        checks++;
        if (lag_at !== 6) begin failures++; $display("FAIL short_lag_entry actual=%0d required=6", lag_at); end
    endtask

    task automatic test_blank_reentry();
        bit ok;
        logic [4:0] at50, at51;
        lead_top = 8'd2; lag_top = 8'd1; blank_top = 8'd3; wd_top = 16'd0;
        at50 = '0; at51 = '0;
        for (int t = 0; t <= 60; t++) begin
            if (t == 50) at50 = {fe_state, tr_switch_tx, lna_en};
            if (t == 51) at51 = {fe_state, tr_switch_tx, lna_en};
            tx_on = (t < 30) || (t >= 50 && t < 60);
            tick();
        end
        checks++;
        if (at50 !== {3'd4, 1'b0, 1'b1}) begin failures++; $display("FAIL reentry_in_blank actual=%b required=%b", at50, {3'd4, 1'b0, 1'b1}); end
        checks++;
        if (at51 !== {3'd1, 1'b1, 1'b0}) begin failures++; $display("FAIL reentry_lead actual=%b required=%b", at51, {3'd1, 1'b1, 1'b0}); end
        tx_on = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL reentry_idle_timeout actual=busy required=idle"); end
        tick();
    endtask

    task automatic test_watchdog();
        bit ok;
        int tmo_first = -1, tmo_cnt = 0, pa_fall = -1, lead_entries = 0, reentry = -1;
        logic sticky_999;
        logic p_pa;
        logic [2:0] p_st;
        lead_top = 8'd2; lag_top = 8'd1; blank_top = 8'd3; wd_top = 16'd3;
        sticky_999 = 1'b0;
        p_pa = pa_en; p_st = fe_state;
        for (int t = 0; t <= 1015; t++) begin
            if (tx_wd_timeout) begin
                tmo_cnt++;
                if (tmo_first < 0) tmo_first = t;
            end
            if (!pa_en && p_pa && pa_fall < 0) pa_fall = t;
            if (fe_state == 3'd1 && p_st != 3'd1) begin
                if (t < 1000) lead_entries++;
                else if (reentry < 0) reentry = t;
            end
            if (t == 999) sticky_999 = tx_fault_sticky;
            p_pa = pa_en; p_st = fe_state;
            tx_on = (t < 1000) || (t >= 1005 && t < 1010);
            tsf   = (t % 100 == 50);
            fclr  = (t == 250);
            tick();
        end
        tsf = 1'b0; fclr = 1'b0; tx_on = 1'b0;
        checks++;
        if (tmo_first !== 251) begin failures++; $display("FAIL wd_timeout_time actual=%0d required=251", tmo_first); end
        checks++;
        if (tmo_cnt !== 1) begin failures++; $display("FAIL wd_timeout_width actual=%0d required=1", tmo_cnt); end
        checks++;
        if (pa_fall !== 251) begin failures++; $display("FAIL wd_pa_drop actual=%0d required=251", pa_fall); end
        checks++;
        if (lead_entries !== 1) begin failures++; $display("FAIL wd_lock_entries actual=%0d required=1", lead_entries); end
        checks++;
        if (reentry !== 1006) begin failures++; $display("FAIL wd_unlock_reentry actual=%0d required=1006", reentry); end
        checks++;
        if (sticky_999 !== 1'b1) begin failures++; $display("FAIL wd_sticky_set_wins actual=%b required=1", sticky_999); end
        wait_idle(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL wd_idle_timeout actual=busy required=idle"); end
        tick(); tick();
        checks++;
        if (tx_fault_sticky !== 1'b1) begin failures++; $display("FAIL wd_sticky_hold actual=%b required=1", tx_fault_sticky); end
        fclr = 1'b1;
        tick();
        fclr = 1'b0;
        checks++;
        if (tx_fault_sticky !== 1'b0) begin failures++; $display("FAIL wd_sticky_clear actual=%b required=0", tx_fault_sticky); end
        wd_top = 16'd0;
    endtask

    task automatic test_zero_tops();
        int lead_cyc = 0, lag_cyc = 0, blank_cyc = 0, pa_rise = -1, tmo_cnt = 0;
        lead_top = 8'd0; lag_top = 8'd0; blank_top = 8'd0; wd_top = 16'd0;
        for (int t = 0; t <= 60; t++) begin
            if (fe_state == 3'd1) lead_cyc++;
            if (fe_state == 3'd3) lag_cyc++;
            if (fe_state == 3'd4) blank_cyc++;
            if (pa_en && pa_rise < 0) pa_rise = t;
            if (tx_wd_timeout) tmo_cnt++;
            tx_on = (t < 50);
            tsf   = (t % 3 == 0);
            tick();
        end
        tsf = 1'b0;
        checks++;
        if ({lead_cyc, lag_cyc, blank_cyc} !== {32'd1, 32'd1, 32'd1}) begin
            failures++;
            $display("FAIL zero_dwell actual=%0d/%0d/%0d required=1/1/1", lead_cyc, lag_cyc, blank_cyc);
        end
        checks++;
        if (pa_rise !== 2) begin failures++; $display("FAIL zero_pa_rise actual=%0d required=2", pa_rise); end
        checks++;
        if (tmo_cnt !== 0) begin failures++; $display("FAIL zero_wd_disabled actual=%0d required=0", tmo_cnt); end
        checks++;
        if ({fe_busy, fe_state} !== 4'b0_000) begin failures++; $display("FAIL zero_back_idle actual=%b required=0000", {fe_busy, fe_state}); end
    endtask

    task automatic test_reset_mid_tx();
        bit ok;
        lead_top = 8'd0; lag_top = 8'd0; blank_top = 8'd0; wd_top = 16'd1;
        tx_on = 1'b1; tsf = 1'b0;
        tick();
        tsf = 1'b1;
        tick();
        tsf = 1'b0; tx_on = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rst_setup_idle_timeout actual=busy required=idle"); end
        tick();
        wd_top = 16'd0; tx_on = 1'b1;
        tick(); tick(); tick();
        checks++;
        if ({fe_state, tx_fault_sticky, pa_en} !== {3'd2, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL rst_pre_tx actual=%b required=%b", {fe_state, tx_fault_sticky, pa_en}, {3'd2, 1'b1, 1'b1});
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({tr_switch_tx, pa_en, lna_en, fe_state, tx_fault_sticky} !== {1'b0, 1'b0, 1'b1, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL rst_mid_tx actual=%b required=%b", {tr_switch_tx, pa_en, lna_en, fe_state, tx_fault_sticky}, {1'b0, 1'b0, 1'b1, 3'd0, 1'b0});
        end
        rst = 1'b0; tx_on = 1'b0;
        tick();
    endtask

    // Reference: phase plus remaining guard cycles and a count of microsecond
    // ticks seen since the burst began.
    task automatic test_random();
        logic [4:0] pins [5];
        int m_ph, m_left, m_pulses, nph, nprint;
        bit m_lock, m_sticky, m_tmo, exp_now;
        logic [9:0] act, req;
        pins = '{5'b00100, 5'b10011, 5'b11011, 5'b10011, 5'b00111};
        rst = 1'b1; tx_on = 1'b0; tsf = 1'b0; fclr = 1'b0;
        tick();
        rst = 1'b0;
        m_ph = PH_IDLE; m_left = 0; m_pulses = 0; m_lock = 0; m_sticky = 0; m_tmo = 0; nprint = 0;
        for (int t = 0; t < 3000; t++) begin
            act = {tr_switch_tx, pa_en, lna_en, rx_blank, fe_busy, tx_wd_timeout, tx_fault_sticky, fe_state};
            req = {pins[m_ph], m_tmo, m_sticky, 3'(m_ph)};
            checks++;
            if (act !== req) begin
                failures++;
                if (nprint < 10) $display("FAIL rand_cycle_%0d actual=%b required=%b", t, act, req);
                nprint++;
            end
            if (m_ph == PH_IDLE && t % 150 == 0) begin
                lead_top  = 8'($urandom_range(0, 3));
                lag_top   = 8'($urandom_range(0, 3));
                blank_top = 8'($urandom_range(0, 3));
                wd_top    = 16'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 19) == 0) tx_on = ~tx_on;
            tsf  = ($urandom_range(0, 9) == 0);
            fclr = ($urandom_range(0, 63) == 0);

            exp_now = 0;
            nph = m_ph;
            if (m_ph == PH_LEAD || m_ph == PH_TX) begin
                if (tsf && m_pulses < 65535) m_pulses++;
                if (wd_top != 0 && m_pulses == int'(wd_top)) exp_now = 1;
            end
            case (m_ph)
                PH_IDLE: begin
                    if (tx_on && !m_lock) begin nph = PH_LEAD; m_pulses = 0; end
                    if (!tx_on) m_lock = 0;
                end
                PH_LEAD:  if (!tx_on || exp_now) nph = PH_LAG; else if (m_left == 1) nph = PH_TX;
                PH_TX:    if (!tx_on || exp_now) nph = PH_LAG;
                PH_LAG:   if (tx_on && !m_lock) nph = PH_LEAD; else if (m_left == 1) nph = PH_BLANK;
                default:  if (tx_on && !m_lock) nph = PH_LEAD; else if (m_left == 1) nph = PH_IDLE;
            endcase
            if (exp_now) m_lock = 1;
            m_sticky = exp_now ? 1'b1 : (fclr ? 1'b0 : m_sticky);
            m_tmo = exp_now;
            if (nph != m_ph) begin
                m_left = (nph == PH_LEAD)  ? int'(lead_top) * SCALE + 1 :
                         (nph == PH_LAG)   ? int'(lag_top) * SCALE + 1 :
                         (nph == PH_BLANK) ? int'(blank_top) * SCALE + 1 : 0;
            end else begin
                m_left--;
            end
            m_ph = nph;
            tick();
        end
        tx_on = 1'b0; tsf = 1'b0; fclr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b1; tx_on = 1'b0; tsf = 1'b0; fclr = 1'b0;
        lead_top = '0; lag_top = '0; blank_top = '0; wd_top = '0;
        tick();
        test_reset();
        test_nominal();
        test_short_tx();
        test_blank_reentry();
        test_watchdog();
        test_zero_tops();
        test_reset_mid_tx();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
